// File: rtl/urng_multi.sv
// urng_multi: NUM_CH independent 64-bit three-component Tausworthe uniform
// generators stepped in lockstep, presented through a valid/ready output.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   en                 run enable; generators advance only when set
//   out_ready          consumer accepts out_data this cycle
//   out_valid          out_data holds an unconsumed sample set
//   out_data           channel c at [c*OUT_W +: OUT_W] (low bits of result)
//   seed_we/ch/sel/data runtime seed write (sel 0=z1, 1=z2, 2=z3, 3=reserved)
//   seed_err           one-cycle pulse when a write is rejected or substituted
//   sample_cnt         wrapping count of accepted transfers
module urng_multi #(
    parameter int          NUM_CH = 4,
    parameter int          OUT_W  = 64,
    parameter logic [63:0] SEED0  = 64'd5030521883283424767,
    parameter logic [63:0] SEED1  = 64'd18445829279364155008,
    parameter logic [63:0] SEED2  = 64'd18436106298727503359,
    parameter int          CNT_W  = 32,
    localparam int         CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [NUM_CH*OUT_W-1:0] out_data,
    input  logic                    seed_we,
    input  logic [CH_W-1:0]         seed_ch,
    input  logic [1:0]              seed_sel,
    input  logic [63:0]             seed_data,
    output logic                    seed_err,
    output logic [CNT_W-1:0]        sample_cnt
);

    localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;
    localparam int          CH_W1  = CH_W + 1;
    localparam logic [CH_W:0] NUM_CH_V = CH_W1'(NUM_CH);

    function automatic logic [63:0] step_z1(input logic [63:0] z);
        return {z[39:1], z[58:34] ^ z[63:39]};
    endfunction

    function automatic logic [63:0] step_z2(input logic [63:0] z);
        return {z[50:6], z[44:26] ^ z[63:45]};
    endfunction

    function automatic logic [63:0] step_z3(input logic [63:0] z);
        return {z[56:9], z[39:24] ^ z[63:48]};
    endfunction

    // A component is degenerate when all bits that feed its recurrence are zero.
    function automatic logic seed_ok(input logic [1:0] sel, input logic [63:0] z);
        case (sel)
            2'd0:    return |z[63:1];
            2'd1:    return |z[63:6];
            default: return |z[63:9];
        endcase
    endfunction

    function automatic logic [63:0] base_seed(input logic [1:0] sel);
        case (sel)
            2'd0:    return SEED0;
            2'd1:    return SEED1;
            default: return SEED2;
        endcase
    endfunction

    // Channels decorrelate by XORing a golden-ratio multiple into the base seeds.
    function automatic logic [63:0] reset_seed(input logic [1:0] sel, input int c);
        logic [63:0] d;
        d = base_seed(sel) ^ (64'(c) * GOLDEN);
        return seed_ok(sel, d) ? d : base_seed(sel);
    endfunction

    logic [63:0] z1_p0 [NUM_CH];
    logic [63:0] z2_p0 [NUM_CH];
    logic [63:0] z3_p0 [NUM_CH];
    logic [63:0] z1_nx [NUM_CH];
    logic [63:0] z2_nx [NUM_CH];
    logic [63:0] z3_nx [NUM_CH];
    logic [63:0] mix_nx [NUM_CH];
    logic [NUM_CH*OUT_W-1:0] res_p0;

    logic        adv;
    logic        addr_ok;
    logic        sel_ok;
    logic        wdata_ok;
    logic        do_write;
    logic        write_err;
    logic [63:0] wdata;

    // Stage p0: generator state and combinational next state / results
    always_comb begin
        z1_nx  = '{default: '0};
        z2_nx  = '{default: '0};
        z3_nx  = '{default: '0};
        mix_nx = '{default: '0};
        res_p0 = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            z1_nx[c]  = step_z1(z1_p0[c]);
            z2_nx[c]  = step_z2(z2_p0[c]);
            z3_nx[c]  = step_z3(z3_p0[c]);
            mix_nx[c] = z1_nx[c] ^ z2_nx[c] ^ z3_nx[c];
            res_p0[c*OUT_W +: OUT_W] = mix_nx[c][OUT_W-1:0];
        end
    end

    always_comb begin
        addr_ok   = ({1'b0, seed_ch} < NUM_CH_V);
        sel_ok    = (seed_sel != 2'd3);
        wdata_ok  = seed_ok(seed_sel, seed_data);
        wdata     = wdata_ok ? seed_data : base_seed(seed_sel);
        do_write  = seed_we & addr_ok & sel_ok;
        write_err = seed_we & ~(addr_ok & sel_ok & wdata_ok);
        // A seed write owns the cycle so the next sample sees the new seed.
        adv       = en & ~seed_we & (~out_valid | out_ready);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                z1_p0[c] <= reset_seed(2'd0, c);
                z2_p0[c] <= reset_seed(2'd1, c);
                z3_p0[c] <= reset_seed(2'd2, c);
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (adv) begin
                    z1_p0[c] <= z1_nx[c];
                    z2_p0[c] <= z2_nx[c];
                    z3_p0[c] <= z3_nx[c];
                end else if (do_write && (seed_ch == CH_W'(c))) begin
                    case (seed_sel)
                        2'd0:    z1_p0[c] <= wdata;
                        2'd1:    z2_p0[c] <= wdata;
                        default: z3_p0[c] <= wdata;
                    endcase
                end
            end
        end
    end

    // Stage p1: registered output sample set and handshake bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            seed_err   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            if (adv) begin
                out_data  <= res_p0;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            seed_err <= write_err;
            if (out_valid && out_ready)
                sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_urng_multi.sv
// tb_urng_multi: randomized self-checking bench for urng_multi. A 4-channel,
// 64-bit instance is checked against a shift/mask Tausworthe reference model
// through a scoreboard; a 1-channel, 40-bit, 4-bit-counter instance covers
// truncation, counter wrap and out-of-range channel writes.
module tb_urng_multi;

    localparam int          NCH = 4;
    localparam int          BW  = 40;
    localparam logic [63:0] S0  = 64'd5030521883283424767;
    localparam logic [63:0] S1  = 64'd18445829279364155008;
    localparam logic [63:0] S2  = 64'd18436106298727503359;

    logic                 clk;
    logic                 rstn;
    logic                 en, out_ready, out_valid;
    logic [NCH*64-1:0]    out_data;
    logic                 seed_we;
    logic [1:0]           seed_ch, seed_sel;
    logic [63:0]          seed_data;
    logic                 seed_err;
    logic [31:0]          sample_cnt;

    logic                 en_b, rdy_b, vld_b, we_b, err_b;
    logic [BW-1:0]        data_b;
    logic [0:0]           ch_b;
    logic [1:0]           sel_b;
    logic [63:0]          sd_b;
    logic [3:0]           cnt_b;

    urng_multi #(.NUM_CH(NCH), .OUT_W(64), .CNT_W(32)) u0 (
        .clk(clk), .rstn(rstn), .en(en), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .seed_we(seed_we),
        .seed_ch(seed_ch), .seed_sel(seed_sel), .seed_data(seed_data),
        .seed_err(seed_err), .sample_cnt(sample_cnt)
    );

    urng_multi #(.NUM_CH(1), .OUT_W(BW), .CNT_W(4)) u1 (
        .clk(clk), .rstn(rstn), .en(en_b), .out_ready(rdy_b),
        .out_valid(vld_b), .out_data(data_b), .seed_we(we_b),
        .seed_ch(ch_b), .seed_sel(sel_b), .seed_data(sd_b),
        .seed_err(err_b), .sample_cnt(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: L'Ecuyer-style shift/mask/xor form of each component.
    function automatic logic [63:0] nx1(input logic [63:0] z);
        return ((z & 64'hFFFF_FFFF_FFFF_FFFE) << 24) ^ (((z << 5) ^ z) >> 39);
    endfunction
    function automatic logic [63:0] nx2(input logic [63:0] z);
        return ((z & 64'hFFFF_FFFF_FFFF_FFC0) << 13) ^ (((z << 19) ^ z) >> 45);
    endfunction
    function automatic logic [63:0] nx3(input logic [63:0] z);
        return ((z & 64'hFFFF_FFFF_FFFF_FE00) << 7) ^ (((z << 24) ^ z) >> 48);
    endfunction
    function automatic bit usable(input int sel, input logic [63:0] z);
        return (sel == 0) ? (z >= 64'd2) : (sel == 1) ? (z >= 64'd64) : (z >= 64'd512);
    endfunction
    function automatic logic [63:0] base(input int sel);
        return (sel == 0) ? S0 : (sel == 1) ? S1 : S2;
    endfunction

    logic [63:0] m1 [NCH];
    logic [63:0] m2 [NCH];
    logic [63:0] m3 [NCH];
    logic [63:0] bm1, bm2, bm3;

    task automatic m_reset();
        logic [63:0] k, d;
        for (int c = 0; c < NCH; c++) begin
            k = 64'(c) * 64'h9E3779B97F4A7C15;
            d = S0 ^ k; m1[c] = usable(0, d) ? d : S0;
            d = S1 ^ k; m2[c] = usable(1, d) ? d : S1;
            d = S2 ^ k; m3[c] = usable(2, d) ? d : S2;
        end
        bm1 = S0; bm2 = S1; bm3 = S2;
    endtask

    task automatic m_next(input int c, output logic [63:0] r);
        m1[c] = nx1(m1[c]);
        m2[c] = nx2(m2[c]);
        m3[c] = nx3(m3[c]);
        r = m1[c] ^ m2[c] ^ m3[c];
    endtask

    task automatic b_next(output logic [63:0] r);
        bm1 = nx1(bm1); bm2 = nx2(bm2); bm3 = nx3(bm3);
        r = bm1 ^ bm2 ^ bm3;
    endtask

    logic              hold_pending = 1'b0;
    logic [NCH*64-1:0] hold_data;
    int                acc = 0;
    int                acc_b = 0;

    // One clock for u0: drive at the negedge, score the transfer the next posedge takes.
    task automatic cycle(input logic e, input logic r);
        logic [63:0] exp;
        @(negedge clk);
        if (hold_pending) begin
            check("stall_valid", {63'b0, out_valid}, 64'd1);
            for (int c = 0; c < NCH; c++)
                check($sformatf("stall_data%0d", c), out_data[c*64 +: 64], hold_data[c*64 +: 64]);
        end
        en = e; out_ready = r; seed_we = 1'b0;
        hold_pending = out_valid && !r;
        hold_data    = out_data;
        if (out_valid && r) begin
            acc++;
            for (int c = 0; c < NCH; c++) begin
                m_next(c, exp);
                check($sformatf("ch%0d_data", c), out_data[c*64 +: 64], exp);
            end
        end
    endtask

    // Issued only with the output drained, so the model state equals the DUT state.
    task automatic seed_write(input int ch, input int sel, input logic [63:0] d, output logic err);
        @(negedge clk);
        en = 1'b1; out_ready = 1'b1; seed_we = 1'b1;
        seed_ch = ch[1:0]; seed_sel = sel[1:0]; seed_data = d;
        hold_pending = 1'b0;
        err = 1'b1;
        if (ch < NCH && sel != 3) begin
            err = !usable(sel, d);
            if (sel == 0) m1[ch] = err ? S0 : d;
            else if (sel == 1) m2[ch] = err ? S1 : d;
            else m3[ch] = err ? S2 : d;
        end
    endtask

    task automatic write_and_check(input int ch, input int sel, input logic [63:0] d);
        logic e;
        cycle(1'b0, 1'b1);
        seed_write(ch, sel, d, e);
        cycle(1'b0, 1'b1);
        check("seed_err", {63'b0, seed_err}, {63'b0, e});
        check("write_blocks_adv", {63'b0, out_valid}, 64'd0);
        cycle(1'b1, 1'b1);
        check("seed_err_pulse", {63'b0, seed_err}, 64'd0);
    endtask

    task automatic bcycle(input logic e, input logic r, input logic w);
        logic [63:0] exp;
        @(negedge clk);
        en_b = e; rdy_b = r; we_b = w;
        if (vld_b && r) begin
            acc_b++;
            b_next(exp);
            check("b_data", {24'b0, data_b}, {24'b0, exp[BW-1:0]});
        end
    endtask

    initial begin
        rstn = 1'b1;
        en = 0; out_ready = 0; seed_we = 0; seed_ch = 0; seed_sel = 0; seed_data = 0;
        en_b = 0; rdy_b = 0; we_b = 0; ch_b = 1'b1; sel_b = 0;
        sd_b = 64'h1234_5678_9ABC_DEF0;
        #1 rstn = 1'b0;
        #2;
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        for (int c = 0; c < NCH; c++)
            check($sformatf("rst_data%0d", c), out_data[c*64 +: 64], 64'd0);
        check("rst_err", {63'b0, seed_err}, 64'd0);
        check("rst_cnt", {32'b0, sample_cnt}, 64'd0);
        check("rst_b_valid", {63'b0, vld_b}, 64'd0);
        m_reset();
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;

        // Full throughput from reset seeds
        for (int i = 0; i < 1001; i++) begin
            cycle(1'b1, 1'b1);
            if (i >= 1) check("thru_valid", {63'b0, out_valid}, 64'd1);
        end
        cycle(1'b0, 1'b0);
        check("cnt_1000", {32'b0, sample_cnt}, 64'd1000);

        // Random enable and backpressure
        for (int i = 0; i < 5000; i++)
            cycle($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));
        cycle(1'b0, 1'b0);
        check("cnt_random", {32'b0, sample_cnt}, 64'(acc));

        // Degenerate z1 replaced by base seed
        write_and_check(0, 0, 64'h1);
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1);

        // Valid z3 on channel 2, others unperturbed
        write_and_check(2, 2, 64'h0123456789ABCDEF);
        for (int i = 0; i < 300; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)));

        // Reserved selector and degenerate z2
        write_and_check(1, 3, 64'hDEAD_BEEF_CAFE_F00D);
        write_and_check(3, 1, 64'h3F);
        for (int i = 0; i < 100; i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a stalled burst
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        check("pre_rst_valid", {63'b0, out_valid}, 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        for (int c = 0; c < NCH; c++)
            check($sformatf("mid_rst_data%0d", c), out_data[c*64 +: 64], 64'd0);
        check("mid_rst_cnt", {32'b0, sample_cnt}, 64'd0);
        hold_pending = 1'b0;
        en = 1'b0;
        acc = 0;
        m_reset();
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 101; i++) cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        check("cnt_after_rst", {32'b0, sample_cnt}, 64'(acc));

        // Single-channel narrow instance: truncation and 4-bit counter wrap
        for (int i = 0; i < 21; i++) bcycle(1'b1, 1'b1, 1'b0);
        bcycle(1'b0, 1'b0, 1'b0);
        check("b_cnt_wrap", {60'b0, cnt_b}, 64'd4);
        // Out-of-range channel write retires the pending sample but writes nothing
        bcycle(1'b1, 1'b1, 1'b1);
        bcycle(1'b0, 1'b1, 1'b0);
        check("b_bad_ch_err", {63'b0, err_b}, 64'd1);
        check("b_retired", {63'b0, vld_b}, 64'd0);
        bcycle(1'b1, 1'b1, 1'b0);
        check("b_err_pulse", {63'b0, err_b}, 64'd0);
        for (int i = 0; i < 10; i++) bcycle(1'b1, 1'b1, 1'b0);
        bcycle(1'b0, 1'b0, 1'b0);
        check("b_cnt_final", {60'b0, cnt_b}, 64'(acc_b % 16));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/urng_multi.md
Name: urng_multi

Overview:
Parametrised multi-channel successor to the single-channel 64-bit three-component Tausworthe URNG in the Rx simulation path. It provides NUM_CH independent generators stepped in lockstep, with a configurable output width and an AXI-style valid/ready output with backpressure. Per-channel seeds can be written at runtime, degenerate seeds are rejected, and accepted samples are counted. It feeds noise/AWGN generators that need several uncorrelated uniform streams per cycle.

Parameters:
NUM_CH, 4, number of generator channels (1..16)
OUT_W, 64, bits output per channel; low OUT_W bits of the 64-bit result (1..64)
SEED0, 64'd5030521883283424767, base reset seed for component z1
SEED1, 64'd18445829279364155008, base reset seed for component z2
SEED2, 64'd18436106298727503359, base reset seed for component z3
CNT_W, 32, width of accepted-sample counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
en  in  1  run enable; generators advance only when en=1
out_ready  in  1  consumer accepts out_data
out_valid  out  1  out_data holds an unconsumed sample set
out_data  out  NUM_CH*OUT_W  channel c occupies bits [c*OUT_W +: OUT_W]
seed_we  in  1  seed write strobe
seed_ch  in  $clog2(NUM_CH) (min 1)  target channel
seed_sel  in  2  0=z1, 1=z2, 2=z3; 3=reserved (write ignored, seed_err pulses)
seed_data  in  64  seed value
seed_err  out  1  one-cycle pulse: write rejected or substituted
sample_cnt  out  CNT_W  count of accepted transfers (out_valid & out_ready)

Behaviour:
- Async reset (rstn=0): channel c components load z1=SEED0^K(c), z2=SEED1^K(c), z3=SEED2^K(c), where K(c)=c*64'h9E3779B97F4A7C15 mod 2^64. Any derived seed failing the validity rule below uses the plain base seed instead. Outputs on reset: out_valid=0, out_data=0, seed_err=0, sample_cnt=0.
- Per-channel step (combinational next state):
  - z1n={z1[39:1], z1[58:34]^z1[63:39]}
  - z2n={z2[50:6], z2[44:26]^z2[63:45]}
  - z3n={z3[56:9], z3[39:24]^z3[63:48]}
  - result = z1n^z2n^z3n, truncated to result[OUT_W-1:0].
- Validity rule: z1[63:1]!=0, z2[63:6]!=0, z3[63:9]!=0.
- adv = en & ~seed_we & (~out_valid | out_ready).
- On adv: every channel's state <= next state; out_data <= all channel results; out_valid <= 1. Latency is 1 cycle from the adv edge to data presented.
- If ~adv & out_ready & out_valid: out_valid <= 0, out_data holds its value.
- Backpressure: while out_valid=1 and out_ready=0, out_data and all state are frozen regardless of en. No sample is ever dropped or duplicated.
- Full throughput: with en=1, out_ready=1 and no seed writes, one new sample set is presented every cycle.
- Seed write (seed_we=1): at the edge, the addressed component of channel seed_ch <= seed_data. If seed_data fails the validity rule for that component, the matching base seed is loaded instead and seed_err pulses. seed_ch>=NUM_CH or seed_sel=3 means no write and seed_err pulses. A seed write blocks adv that cycle; a pending out_valid is still retired if out_ready=1. The first sample after a write uses the new seed.
- sample_cnt increments on every cycle with out_valid & out_ready and wraps modulo 2^CNT_W.
- en deasserted: no advance; an existing valid sample stays until consumed.
- Reset asserted mid-stream: immediate return to reset values, independent of clk.

Test Plan:
- Reset, NUM_CH=1, OUT_W=64, en=1, out_ready=1 for 1000 cycles -> out_data matches C taus64 model from base seeds sample by sample; sample_cnt=1000.
- NUM_CH=4, out_ready toggled pseudo-randomly (50%) over 5000 cycles -> every channel's accepted sequence equals its model sequence with no gaps or repeats; out_data stable while out_valid=1 and out_ready=0.
- Write seed_sel=0, seed_data=64'h1 (z1[63:1]=0) -> seed_err pulses 1 cycle, z1 equals SEED0; next sample matches model seeded with SEED0.
- Write channel 2, z3=64'h0123456789ABCDEF, then run -> channel 2 stream matches model with that z3; channels 0, 1 and 3 are unperturbed.
- Preload sample_cnt near wrap (CNT_W=4 build), accept 20 samples -> sample_cnt=4.
- Assert rstn=0 mid-burst with out_valid=1 -> out_valid=0, out_data=0 immediately; after release the first sample equals sample 0 of the model.
